// File: rtl/add_sub_pkg.sv
// Shared types for the chunk-serial adder/subtractor: FSM state encoding and op codes.
package add_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/add_sub_chunk.sv
// Combinational CHUNKW-bit ripple adder slice; also exposes the carry into its top bit
// so the parent can form signed overflow on the last chunk.
module add_sub_chunk #(
    parameter int CHUNKW = 2
) (
    input  logic [CHUNKW-1:0] a_i,
    input  logic [CHUNKW-1:0] b_i,
    input  logic              cin_i,
    output logic [CHUNKW-1:0] sum_o,
    output logic              cout_o,
    output logic              cmsb_o
);

    logic c;

    always_comb begin
        c      = cin_i;
        sum_o  = '0;
        cmsb_o = 1'b0;
        for (int i = 0; i < CHUNKW; i++) begin
            if (i == CHUNKW - 1) cmsb_o = c;
            sum_o[i] = a_i[i] ^ b_i[i] ^ c;
            c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
        end
        cout_o = c;
    end

endmodule

// File: rtl/add_sub_seq.sv
// Chunk-serial add/sub with registered carry: NCHUNK cycles of compute, then a DONE state that
// holds result and flags until the consumer accepts. o_ready is high only while idle.
module add_sub_seq
    import add_sub_pkg::*;
#(
    parameter int DATAW  = 8,
    parameter int CHUNKW = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [DATAW-1:0] i_dataa,
    input  logic [DATAW-1:0] i_datab,
    input  logic             i_op,
    input  logic             i_signed,
    input  logic             i_sat,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [DATAW-1:0] o_result,
    output logic             o_carry,
    output logic             o_ovf,
    output logic             o_zero
);

    if (CHUNKW < 1) begin : g_bad_chunkw
        $error("add_sub_seq: CHUNKW must be at least 1");
    end else if (DATAW % CHUNKW != 0) begin : g_bad_dataw
        $error("add_sub_seq: DATAW must be a multiple of CHUNKW");
    end

    localparam int NCHUNK = DATAW / CHUNKW;
    localparam int CNTW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNTW-1:0] LAST = CNTW'(NCHUNK - 1);

    state_t            state_q, state_d;
    logic [DATAW-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic              op_q, op_d, sgn_q, sgn_d, sat_q, sat_d, carry_q, carry_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [DATAW-1:0]  res_q, res_d;
    logic              cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

    logic [CHUNKW-1:0] s_chunk;
    logic              c_out, c_msb;
    logic [DATAW-1:0]  sum_full, sat_val, final_res;
    logic              ovf_raw;

    add_sub_chunk #(.CHUNKW(CHUNKW)) u_chunk (
        .a_i    (a_q[cnt_q*CHUNKW +: CHUNKW]),
        .b_i    (b_q[cnt_q*CHUNKW +: CHUNKW]),
        .cin_i  (carry_q),
        .sum_o  (s_chunk),
        .cout_o (c_out),
        .cmsb_o (c_msb)
    );

    // Full-width sum as it will look once the current chunk lands; only consumed on the last chunk.
    always_comb begin
        sum_full = sum_q;
        sum_full[cnt_q*CHUNKW +: CHUNKW] = s_chunk;
    end

    assign ovf_raw = sgn_q ? (c_msb ^ c_out) : ((op_q == OP_SUB) ? ~c_out : c_out);

    assign sat_val = sgn_q ? (a_q[DATAW-1] ? {1'b1, {(DATAW-1){1'b0}}} : {1'b0, {(DATAW-1){1'b1}}})
                           : ((op_q == OP_SUB) ? '0 : '1);

    assign final_res = (sat_q && ovf_raw) ? sat_val : sum_full;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        op_d    = op_q;
        sgn_d   = sgn_q;
        sat_d   = sat_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    a_d     = i_dataa;
                    b_d     = i_datab ^ {DATAW{i_op}};
                    op_d    = i_op;
                    sgn_d   = i_signed;
                    sat_d   = i_sat;
                    carry_d = i_op;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                sum_d   = sum_full;
                carry_d = c_out;
                cnt_d   = cnt_q + CNTW'(1);
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    res_d   = final_res;
                    cout_d  = c_out;
                    ovf_d   = ovf_raw;
                    zero_d  = (final_res == '0);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (i_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            op_q    <= 1'b0;
            sgn_q   <= 1'b0;
            sat_q   <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            op_q    <= op_d;
            sgn_q   <= sgn_d;
            sat_q   <= sat_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign o_ready  = (state_q == IDLE);
    assign o_valid  = (state_q == DONE);
    assign o_result = res_q;
    assign o_carry  = cout_q;
    assign o_ovf    = ovf_q;
    assign o_zero   = zero_q;

endmodule

// File: tb/tb_add_sub_seq.sv
// Drives a 2-bit-chunk and a single-chunk instance in lockstep and checks both against an
// arithmetic reference model, with directed corner cases followed by random operations.
module tb_add_sub_seq;

    logic       i_clk, i_rst, i_valid, i_op, i_signed, i_sat, i_ready;
    logic [7:0] i_dataa, i_datab;
    logic       o_ready, o_valid, o_carry, o_ovf, o_zero;
    logic [7:0] o_result;
    logic       o_ready8, o_valid8, o_carry8, o_ovf8, o_zero8;
    logic [7:0] o_result8;

    int checks   = 0;
    int failures = 0;

    logic [7:0] obs_res;
    logic       obs_c, obs_v, obs_z;

    add_sub_seq #(.DATAW(8), .CHUNKW(2)) u_dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_dataa(i_dataa), .i_datab(i_datab), .i_op(i_op), .i_signed(i_signed), .i_sat(i_sat),
        .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
        .o_carry(o_carry), .o_ovf(o_ovf), .o_zero(o_zero)
    );

    add_sub_seq #(.DATAW(8), .CHUNKW(8)) u_dut8 (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready8),
        .i_dataa(i_dataa), .i_datab(i_datab), .i_op(i_op), .i_signed(i_signed), .i_sat(i_sat),
        .o_valid(o_valid8), .i_ready(i_ready), .o_result(o_result8),
        .o_carry(o_carry8), .o_ovf(o_ovf8), .o_zero(o_zero8)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns {result, carry, ovf, zero} from integer arithmetic on the operand values.
    function automatic logic [10:0] model(input logic [7:0] a, input logic [7:0] b,
                                          input logic op, input logic sg, input logic sat);
        int ua, ub, sa, sb, ur, sr;
        logic c, v;
        logic [7:0] res;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        ur = op ? ua - ub : ua + ub;
        sr = op ? sa - sb : sa + sb;
        res = ur[7:0];
        c = op ? (ua >= ub) : (ur > 255);
        v = sg ? ((sr > 127) || (sr < -128)) : (op ? (ua < ub) : (ur > 255));
        if (sat && v) res = sg ? ((sr > 127) ? 8'h7F : 8'h80) : (op ? 8'h00 : 8'hFF);
        return {res, c, v, (res == 8'h00)};
    endfunction

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic op,
                          input logic sg, input logic sat, input int hold);
        logic [10:0] exp;
        int lat, lat8;
        exp = model(a, b, op, sg, sat);
        @(negedge i_clk);
        chk("ready_before_accept", {31'd0, o_ready}, 32'd1);
        i_valid = 1'b1; i_dataa = a; i_datab = b; i_op = op; i_signed = sg; i_sat = sat;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        i_dataa = 8'($urandom); i_datab = 8'($urandom); i_op = 1'($urandom);
        chk("busy_not_ready", {31'd0, o_ready}, 32'd0);
        lat = 0; lat8 = 0;
        do begin
            @(posedge i_clk); #1;
            lat++;
            if (o_valid8 && lat8 == 0) lat8 = lat;
        end while (!o_valid && lat < 20);
        chk("latency_chunk2", lat, 4);
        chk("latency_chunk8", lat8, 1);
        chk("result", {24'd0, o_result}, {24'd0, exp[10:3]});
        chk("carry", {31'd0, o_carry}, {31'd0, exp[2]});
        chk("ovf", {31'd0, o_ovf}, {31'd0, exp[1]});
        chk("zero", {31'd0, o_zero}, {31'd0, exp[0]});
        chk("result8", {20'd0, o_result8, o_carry8, o_ovf8, o_zero8}, {21'd0, exp});
        obs_res = o_result; obs_c = o_carry; obs_v = o_ovf; obs_z = o_zero;
        for (int k = 0; k < hold; k++) begin
            @(negedge i_clk);
            i_valid = 1'b1; i_dataa = 8'($urandom); i_datab = 8'($urandom);
            @(posedge i_clk); #1;
            i_valid = 1'b0;
            chk("hold_valid", {30'd0, o_valid, o_ready}, 32'd2);
            chk("hold_outputs", {20'd0, o_result, o_carry, o_ovf, o_zero}, {21'd0, exp});
        end
        @(negedge i_clk);
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        chk("after_handshake", {28'd0, o_valid, o_ready, o_valid8, o_ready8}, 32'b0101);
    endtask

    initial begin
        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_op = 1'b0; i_signed = 1'b0;
        i_sat = 1'b0; i_dataa = 8'h00; i_datab = 8'h00;
        repeat (3) @(posedge i_clk);
        #1;
        chk("reset_ctrl", {30'd0, o_ready, o_valid}, 32'b10);
        chk("reset_data", {20'd0, o_result, o_carry, o_ovf, o_zero}, 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;

        run_op(8'd200, 8'd100, 1'b0, 1'b0, 1'b0, 0);
        chk("t1_uadd", {21'd0, obs_res, obs_c, obs_v, obs_z}, {21'd0, 8'h2C, 3'b110});
        run_op(8'd200, 8'd100, 1'b0, 1'b0, 1'b1, 0);
        chk("t2_uadd_sat", {21'd0, obs_res, obs_c, obs_v, obs_z}, {21'd0, 8'hFF, 3'b110});
        run_op(8'd3, 8'd5, 1'b1, 1'b0, 1'b1, 0);
        chk("t2_usub_sat", {21'd0, obs_res, obs_c, obs_v}, {22'd0, 8'h00, 2'b01});
        run_op(8'h80, 8'h01, 1'b1, 1'b1, 1'b0, 0);
        chk("t3_ssub", {22'd0, obs_res, obs_v}, {23'd0, 8'h7F, 1'b1});
        run_op(8'h80, 8'h01, 1'b1, 1'b1, 1'b1, 0);
        chk("t3_ssub_sat", {22'd0, obs_res, obs_v}, {23'd0, 8'h80, 1'b1});
        run_op(8'h7F, 8'h01, 1'b0, 1'b1, 1'b1, 0);
        chk("t3_sadd_sat", {22'd0, obs_res, obs_v}, {23'd0, 8'h7F, 1'b1});
        run_op(8'd5, 8'd5, 1'b1, 1'b0, 1'b0, 0);
        chk("t4_zero", {21'd0, obs_res, obs_c, obs_v, obs_z}, {21'd0, 8'h00, 3'b101});
        run_op(8'h5A, 8'h21, 1'b0, 1'b0, 1'b0, 3);
        chk("t5_backpressure", {24'd0, obs_res}, 32'h7B);

        // Abort in the second BUSY cycle; nothing partial may surface.
        @(negedge i_clk);
        i_valid = 1'b1; i_dataa = 8'h33; i_datab = 8'h44; i_op = 1'b0; i_signed = 1'b0; i_sat = 1'b0;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        #1;
        chk("t6_reset_ctrl", {30'd0, o_valid, o_ready}, 32'b01);
        chk("t6_reset_data", {20'd0, o_result, o_carry, o_ovf, o_zero}, 32'd0);
        repeat (2) begin
            @(posedge i_clk); #1;
            chk("t6_reset_held", {29'd0, o_valid, o_ready, o_valid8}, 32'b010);
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        run_op(8'd10, 8'd20, 1'b0, 1'b0, 1'b0, 0);
        chk("t6_after_reset", {21'd0, obs_res, obs_c, obs_v, obs_z}, {21'd0, 8'h1E, 3'b000});

        for (int n = 0; n < 40; n++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
